register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named CLK and RESET.
REQ-002 Port CLK SHALL be: input, 1 bit, clock; all state updates occur on its rising edge.
REQ-003 Port RESET SHALL be: input, 1 bit, synchronous active-high reset.
REQ-004 Port ADRS1 SHALL be: input, 5 bits, read address for port 1.
REQ-005 Port ADRS2 SHALL be: input, 5 bits, read address for port 2.
REQ-006 Port WB_ADDRESS SHALL be: input, 5 bits, write-back destination register.
REQ-007 Port WRITE_ENABLE SHALL be: input, 1 bit, write strobe, sampled at the rising CLK edge.
REQ-008 Port WRITE_DATA SHALL be: input, 32 bits, write-back data.
REQ-009 Port DATA_OUT1 SHALL be: output, 32 bits, contents of register ADRS1.
REQ-010 Port DATA_OUT2 SHALL be: output, 32 bits, contents of register ADRS2.
REQ-011 The block SHALL have no parameters; XLEN is fixed at 32 and the register count at 32 (x0..x31).

Function
REQ-012 The block SHALL hold 32 registers of 32 bits, implementing the RV32 integer register file.
REQ-013 Reads SHALL be asynchronous: DATA_OUTn = reg[ADRSn], with zero-cycle latency and no clock involved.
REQ-014 Write SHALL occur at a rising CLK edge when WRITE_ENABLE=1 and RESET=0 and WB_ADDRESS!=0: reg[WB_ADDRESS] <= WRITE_DATA.
REQ-015 Register x0 SHALL be hardwired to zero: writes to address 0 are ignored, and reads of address 0 return 32'h0 on either port.
REQ-016 Writes SHALL be visible on read ports from the instant after the committing edge, i.e. one-cycle write-to-read latency without bypass.
REQ-017 Both read ports SHALL be independent; ADRS1==ADRS2 returns identical data on both ports.
REQ-018 When WRITE_ENABLE=0, register contents SHALL be unchanged regardless of WB_ADDRESS or WRITE_DATA.
REQ-019 X or Z on unused inputs (WB_ADDRESS, WRITE_DATA) while WRITE_ENABLE=0 SHALL NOT corrupt state.

Reset
REQ-020 When RESET=1 at a rising CLK edge, all 32 registers SHALL be cleared to 32'h0.
REQ-021 RESET SHALL take priority over a simultaneous write; the write is discarded.
REQ-022 After reset, DATA_OUT1 and DATA_OUT2 SHALL read 32'h0 for every address.
REQ-023 Assertion of RESET without a clock edge SHALL NOT change state (synchronous reset only).
REQ-024 Reset asserted mid-operation SHALL clear all previously written values at the next edge.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN SHALL control same-cycle write forwarding on the read ports.
REQ-026 With REGFILE_BYPASS_EN defined: if WRITE_ENABLE=1, RESET=0, WB_ADDRESS!=0 and WB_ADDRESS==ADRSn, then DATA_OUTn SHALL combinationally equal WRITE_DATA before the edge.
REQ-027 Without REGFILE_BYPASS_EN: read ports SHALL return the stored (old) value until the write edge commits.
REQ-028 With either setting, address 0 SHALL always read 32'h0.

Verification
REQ-029 Reset scenario: RESET=1 for one edge, then all ADRS1/ADRS2 values 0..31 -> DATA_OUT1/DATA_OUT2 = 32'h0.
REQ-030 Write/read scenario: WRITE_ENABLE=1, WB_ADDRESS=2, WRITE_DATA=32'hDEADBEEF for one edge, then WRITE_ENABLE=0, ADRS1=2 -> DATA_OUT1=32'hDEADBEEF.
REQ-031 Dual-read scenario: write x3=32'hCAFEBABE, then ADRS1=3, ADRS2=2 -> DATA_OUT1=32'hCAFEBABE, DATA_OUT2=32'hDEADBEEF.
REQ-032 x0 scenario: write WB_ADDRESS=0, WRITE_DATA=32'hFFFFFFFF, then ADRS1=0 -> DATA_OUT1=32'h0.
REQ-033 Reset-priority scenario: RESET=1 and WRITE_ENABLE=1 (x5=32'h12345678) at the same edge -> x5 reads 32'h0, and x2/x3 also read 32'h0.
REQ-034 Bypass scenario: ADRS1=4 while writing x4=32'hA5A5A5A5, sampled before the edge -> DATA_OUT1=32'hA5A5A5A5 with REGFILE_BYPASS_EN, old value (32'h0) without it.

Source files
------------

// File: rtl/register_file.sv
// RV32 integer register file: 32 x 32-bit, two async read ports, one write port.
// Optional REGFILE_BYPASS_EN forwards a same-cycle write onto matching read ports.
module register_file (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ADRS1,
  input  logic [4:0]  ADRS2,
  input  logic [4:0]  WB_ADDRESS,
  input  logic        WRITE_ENABLE,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] DATA_OUT1,
  output logic [31:0] DATA_OUT2
);

  logic [31:0] regs [0:31];
  logic        wr_live;

  // x0 is never written, so it stays zero after the first reset
  assign wr_live = WRITE_ENABLE && !RESET && (WB_ADDRESS != 5'd0);

  // reset clears everything and wins over a simultaneous write
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (wr_live) begin
      regs[WB_ADDRESS] <= WRITE_DATA;
    end
  end

  // async reads; x0 forced to zero independent of storage
  always_comb begin
    DATA_OUT1 = (ADRS1 == 5'd0) ? 32'h0 : regs[ADRS1];
    DATA_OUT2 = (ADRS2 == 5'd0) ? 32'h0 : regs[ADRS2];
`ifdef REGFILE_BYPASS_EN
    if (wr_live && (WB_ADDRESS == ADRS1)) begin
      DATA_OUT1 = WRITE_DATA;
    end
    if (wr_live && (WB_ADDRESS == ADRS2)) begin
      DATA_OUT2 = WRITE_DATA;
    end
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_register_file;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  ADRS1, ADRS2, WB_ADDRESS;
  logic        WRITE_ENABLE;
  logic [31:0] WRITE_DATA;
  logic [31:0] DATA_OUT1, DATA_OUT2;

  int passed = 0;
  int total  = 0;

  logic [31:0] model [32];

  register_file dut (
    .CLK(CLK),
    .RESET(RESET),
    .ADRS1(ADRS1),
    .ADRS2(ADRS2),
    .WB_ADDRESS(WB_ADDRESS),
    .WRITE_ENABLE(WRITE_ENABLE),
    .WRITE_DATA(WRITE_DATA),
    .DATA_OUT1(DATA_OUT1),
    .DATA_OUT2(DATA_OUT2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] expect_rd(
      input logic [4:0] a, input logic rst, input logic we,
      input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] v;
    v = (a == 0) ? 32'h0 : model[a];
`ifdef REGFILE_BYPASS_EN
    if (we === 1'b1 && !rst && wa != 0 && wa == a) v = wd;
`endif
    return v;
  endfunction

  // Called at a negedge: drive, check reads before the edge,
  // let the edge commit, update the model, return at next negedge.
  task automatic cyc(input string tag, input logic rst, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input bit do_chk);
    RESET = rst; WRITE_ENABLE = we; WB_ADDRESS = wa;
    WRITE_DATA = wd; ADRS1 = a1; ADRS2 = a2;
    #1;
    if (do_chk) begin
      chk({tag, ".p1"}, DATA_OUT1, expect_rd(a1, rst, we, wa, wd));
      chk({tag, ".p2"}, DATA_OUT2, expect_rd(a2, rst, we, wa, wd));
    end
    @(posedge CLK);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we === 1'b1 && wa != 0) begin
      model[wa] = wd;
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    cyc("idle", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    RESET = 1'b1; WRITE_ENABLE = 1'b0; WB_ADDRESS = 5'd0;
    WRITE_DATA = 32'h0; ADRS1 = 5'd0; ADRS2 = 5'd0;
    @(negedge CLK);

    // reset for one edge, then sweep every address on both ports
    cyc("rst", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    RESET = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ADRS1 = 5'(i); ADRS2 = 5'(31 - i);
      #0.1;
      chk($sformatf("rst_sweep1_%0d", i), DATA_OUT1, 32'h0);
      chk($sformatf("rst_sweep2_%0d", 31 - i), DATA_OUT2, 32'h0);
    end

    // write x2, then read it
    cyc("wr2", 1'b0, 1'b1, 5'd2, 32'hDEADBEEF, 5'd1, 5'd1, 1'b1);
    ADRS1 = 5'd2; WRITE_ENABLE = 1'b0; #1;
    chk("rd2", DATA_OUT1, 32'hDEADBEEF);

    // write x3, dual read
    cyc("wr3", 1'b0, 1'b1, 5'd3, 32'hCAFEBABE, 5'd1, 5'd1, 1'b1);
    ADRS1 = 5'd3; ADRS2 = 5'd2; WRITE_ENABLE = 1'b0; #1;
    chk("dual1", DATA_OUT1, 32'hCAFEBABE);
    chk("dual2", DATA_OUT2, 32'hDEADBEEF);

    // same address on both ports
    ADRS1 = 5'd3; ADRS2 = 5'd3; #1;
    chk("same1", DATA_OUT1, 32'hCAFEBABE);
    chk("same2", DATA_OUT2, 32'hCAFEBABE);
    @(negedge CLK);

    // write to x0 ignored
    cyc("wr0", 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd2, 5'd3, 1'b1);
    ADRS1 = 5'd0; ADRS2 = 5'd0; WRITE_ENABLE = 1'b0; #1;
    chk("x0_p1", DATA_OUT1, 32'h0);
    chk("x0_p2", DATA_OUT2, 32'h0);
    @(negedge CLK);

    // RESET pulse between edges does nothing
    ADRS1 = 5'd2; ADRS2 = 5'd3;
    RESET = 1'b1; #1; RESET = 1'b0; #1;
    @(posedge CLK); #1;
    chk("async_rst1", DATA_OUT1, 32'hDEADBEEF);
    chk("async_rst2", DATA_OUT2, 32'hCAFEBABE);
    @(negedge CLK);

    // WE=0 with X/garbage on write inputs keeps state
    cyc("we0x", 1'b0, 1'b0, 5'bx, 32'hx, 5'd2, 5'd3, 1'b0);
    cyc("we0", 1'b0, 1'b0, 5'd2, 32'h11111111, 5'd2, 5'd3, 1'b1);
    ADRS1 = 5'd2; ADRS2 = 5'd3; WRITE_ENABLE = 1'b0; #1;
    chk("we0_hold1", DATA_OUT1, 32'hDEADBEEF);
    chk("we0_hold2", DATA_OUT2, 32'hCAFEBABE);
    @(negedge CLK);

    // reset priority over simultaneous write to x5
    cyc("rstpri", 1'b1, 1'b1, 5'd5, 32'h12345678, 5'd2, 5'd3, 1'b0);
    RESET = 1'b0; WRITE_ENABLE = 1'b0;
    ADRS1 = 5'd5; ADRS2 = 5'd2; #1;
    chk("rstpri_x5", DATA_OUT1, 32'h0);
    chk("rstpri_x2", DATA_OUT2, 32'h0);
    ADRS2 = 5'd3; #1;
    chk("rstpri_x3", DATA_OUT2, 32'h0);
    @(negedge CLK);

    // bypass: read x4 while it is being written, before the edge
    RESET = 1'b0; WRITE_ENABLE = 1'b1; WB_ADDRESS = 5'd4;
    WRITE_DATA = 32'hA5A5A5A5; ADRS1 = 5'd4; ADRS2 = 5'd0; #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass", DATA_OUT1, 32'hA5A5A5A5);
`else
    chk("bypass", DATA_OUT1, 32'h0);
`endif
    chk("bypass_x0", DATA_OUT2, 32'h0);
    @(posedge CLK); model[4] = 32'hA5A5A5A5;
    #1; WRITE_ENABLE = 1'b0; #1;
    chk("after_wr4", DATA_OUT1, 32'hA5A5A5A5);
    @(negedge CLK);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic        r, w;
      logic [4:0]  wa, a1, a2;
      logic [31:0] wd;
      r  = ($urandom_range(0, 39) == 0);
      w  = ($urandom_range(0, 2) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 5) == 0) ? a1 : 5'($urandom_range(0, 31));
      if (!w && $urandom_range(0, 3) == 0) begin
        wa = 5'bx; wd = 32'hx;
      end
      cyc($sformatf("rnd%0d", n), r, w, wa, wd, a1, a2, 1'b1);
    end

    // final sweep of the whole file
    RESET = 1'b0; WRITE_ENABLE = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ADRS1 = 5'(i); ADRS2 = 5'(i); #1;
      chk($sformatf("final1_%0d", i), DATA_OUT1,
          (i == 0) ? 32'h0 : model[i]);
      chk($sformatf("final2_%0d", i), DATA_OUT2,
          (i == 0) ? 32'h0 : model[i]);
    end

    // mid-operation reset clears everything
    idle();
    cyc("midrst", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    RESET = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ADRS1 = 5'(i); ADRS2 = 5'(i); #1;
      chk($sformatf("midrst_%0d", i), DATA_OUT1 | DATA_OUT2, 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
